n101_uart_tx: RTL and testbench



---
 rtl/n101_uart_tx.sv | 98 +++++++++
 tb/tb_n101_uart_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/n101_uart_tx.sv
// UART transmit serializer: pulls bytes over ready/valid and sends start, 8 data
// bits LSB-first and 1 or 2 stop bits, each bit lasting io_div+1 clocks.
module n101_uart_tx #(
    parameter int DIV_W     = 16,
    parameter int DATA_BITS = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             io_en,
    input  logic [DIV_W-1:0] io_div,
    input  logic             io_nstop,
    input  logic             io_in_valid,
    input  logic [7:0]       io_in_bits,
    output logic             io_in_ready,
    output logic             io_out,
    output logic             io_busy
);

    localparam int FRAME_W = DATA_BITS + 3;
    localparam logic [3:0] BASE_BITS = 4'(DATA_BITS + 2);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   prescale_reg, prescale_next;
    logic [3:0]         count_reg, count_next;
    logic [FRAME_W-1:0] shift_reg, shift_next;
    logic [FRAME_W-1:0] shift_shifted;
    logic               accept;
    logic               tick;

    // Right shift with ones filled in at the top so trailing bits read as stop bits.
    genvar gi;
    generate
        for (gi = 0; gi < FRAME_W; gi++) begin : g_shift
            if (gi == FRAME_W - 1) begin : g_top
                assign shift_shifted[gi] = 1'b1;
            end else begin : g_body
                assign shift_shifted[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    assign io_in_ready = io_en & (state_reg == IDLE);
    assign accept      = io_in_valid & io_in_ready;
    assign tick        = (state_reg == SHIFT) && (prescale_reg == '0);
    assign io_busy     = (state_reg == SHIFT);
    assign io_out      = (state_reg == SHIFT) ? shift_reg[0] : 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            prescale_reg <= '0;
            count_reg    <= '0;
            shift_reg    <= '1;
        end else begin
            state_reg    <= state_next;
            prescale_reg <= prescale_next;
            count_reg    <= count_next;
            shift_reg    <= shift_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        prescale_next = prescale_reg;
        count_next    = count_reg;
        shift_next    = shift_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next    = SHIFT;
                    shift_next    = {2'b11, io_in_bits, 1'b0};
                    count_next    = BASE_BITS + {3'b000, io_nstop};
                    prescale_next = io_div;
                end
            end
            SHIFT: begin
                if (tick) begin
                    // Divisor is sampled only at reload, so a mid-frame change never cuts a bit short.
                    shift_next    = shift_shifted;
                    count_next    = count_reg - 4'd1;
                    prescale_next = io_div;
                    if (count_reg == 4'd1) begin
                        state_next = IDLE;
                    end
                end else begin
                    prescale_next = prescale_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_n101_uart_tx.sv
// Directed self-checking bench for n101_uart_tx; outputs sampled on the falling edge.
module tb_n101_uart_tx;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        io_en = 1'b0;
    logic [15:0] io_div = 16'd3;
    logic        io_nstop = 1'b0;
    logic        io_in_valid = 1'b0;
    logic [7:0]  io_in_bits = 8'h00;
    logic        io_in_ready;
    logic        io_out;
    logic        io_busy;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    n101_uart_tx #(.DIV_W(16), .DATA_BITS(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .io_en       (io_en),
        .io_div      (io_div),
        .io_nstop    (io_nstop),
        .io_in_valid (io_in_valid),
        .io_in_bits  (io_in_bits),
        .io_in_ready (io_in_ready),
        .io_out      (io_out),
        .io_busy     (io_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit idx: start, data LSB-first, then stop/idle ones.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else return 1'b1;
    endfunction

    // Called at a falling edge with the DUT idle and enabled.
    task automatic run_frame(input string name, input logic [7:0] b, input logic [15:0] div,
                             input logic nstop);
        int n;
        int len;
        n = 10 + int'(nstop);
        len = n * (int'(div) + 1);
        io_div = div;
        io_nstop = nstop;
        io_in_bits = b;
        io_in_valid = 1'b1;
        check($sformatf("%s ready_before", name), {31'd0, io_in_ready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        io_in_valid = 1'b0;
        io_in_bits = ~b;
        io_nstop = ~nstop;
        for (int k = 0; k < len; k++) begin
            check($sformatf("%s out[%0d]", name, k), {31'd0, io_out},
                  {31'd0, frame_bit(b, k / (int'(div) + 1))});
            check($sformatf("%s busy[%0d]", name, k), {31'd0, io_busy}, 32'd1);
            check($sformatf("%s ready[%0d]", name, k), {31'd0, io_in_ready}, 32'd0);
            @(negedge clock);
        end
        check($sformatf("%s end_busy", name), {31'd0, io_busy}, 32'd0);
        check($sformatf("%s end_out", name), {31'd0, io_out}, 32'd1);
        check($sformatf("%s end_ready", name), {31'd0, io_in_ready}, 32'd1);
        $display("frame %s byte=%02h div=%0d nstop=%0d busy_clocks=%0d", name, b, div, nstop, len);
    endtask

    initial begin
        int low_cnt;
        logic exp_bit;
        logic [7:0] b2b [2];

        // Reset state
        repeat (3) @(negedge clock);
        check("rst out", {31'd0, io_out}, 32'd1);
        check("rst busy", {31'd0, io_busy}, 32'd0);
        check("rst ready_en0", {31'd0, io_in_ready}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        io_en = 1'b1;
        #1;
        check("rst ready_en1", {31'd0, io_in_ready}, 32'd1);
        @(negedge clock);
        $display("reset checks done");

        run_frame("single_a5", 8'hA5, 16'd3, 1'b0);
        @(negedge clock);
        run_frame("two_stop_00", 8'h00, 16'd3, 1'b1);
        @(negedge clock);

        // Back-to-back with valid held: accepts 11 clocks apart, one idle clock between.
        b2b[0] = 8'h55;
        b2b[1] = 8'hFF;
        io_div = 16'd0;
        io_nstop = 1'b0;
        io_in_bits = b2b[0];
        io_in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        io_in_bits = b2b[1];
        for (int k = 0; k < 22; k++) begin
            if (k == 10 || k == 21) begin
                check($sformatf("b2b idle_busy[%0d]", k), {31'd0, io_busy}, 32'd0);
                check($sformatf("b2b idle_out[%0d]", k), {31'd0, io_out}, 32'd1);
                check($sformatf("b2b idle_ready[%0d]", k), {31'd0, io_in_ready}, 32'd1);
            end else begin
                exp_bit = (k < 10) ? frame_bit(b2b[0], k) : frame_bit(b2b[1], k - 11);
                check($sformatf("b2b out[%0d]", k), {31'd0, io_out}, {31'd0, exp_bit});
                check($sformatf("b2b busy[%0d]", k), {31'd0, io_busy}, 32'd1);
            end
            if (k == 11) io_in_valid = 1'b0;
            @(negedge clock);
        end
        $display("frame back_to_back bytes=55,ff div=0 accepts 11 clocks apart");

        // Mid-frame: divisor 3->1 and enable dropped during frame bit 4.
        io_div = 16'd3;
        io_in_bits = 8'h96;
        io_in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        io_in_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            exp_bit = (k < 20) ? frame_bit(8'h96, k / 4) : frame_bit(8'h96, 5 + (k - 20) / 2);
            check($sformatf("mid out[%0d]", k), {31'd0, io_out}, {31'd0, exp_bit});
            check($sformatf("mid busy[%0d]", k), {31'd0, io_busy}, 32'd1);
            if (k == 17) begin
                io_div = 16'd1;
                io_en = 1'b0;
            end
            @(negedge clock);
        end
        io_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mid after_busy[%0d]", k), {31'd0, io_busy}, 32'd0);
            check($sformatf("mid after_ready[%0d]", k), {31'd0, io_in_ready}, 32'd0);
            check($sformatf("mid after_out[%0d]", k), {31'd0, io_out}, 32'd1);
            @(negedge clock);
        end
        $display("frame mid_change byte=96 div 3->1 busy_clocks=30, en dropped");
        io_in_valid = 1'b0;
        io_en = 1'b1;
        io_div = 16'd3;
        @(negedge clock);

        // Reset during data bit 2 (line low for 0xC3), then a clean frame.
        io_in_bits = 8'hC3;
        io_in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        io_in_valid = 1'b0;
        repeat (13) @(negedge clock);
        check("rst_mid out_before", {31'd0, io_out}, 32'd0);
        check("rst_mid busy_before", {31'd0, io_busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid out_async", {31'd0, io_out}, 32'd1);
        check("rst_mid busy_async", {31'd0, io_busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rst_mid ready_after", {31'd0, io_in_ready}, 32'd1);
        $display("reset mid-frame: line released asynchronously");
        @(negedge clock);
        run_frame("after_reset_3a", 8'h3A, 16'd3, 1'b0);
        @(negedge clock);

        // Maximum divisor: start bit lasts 65536 clocks.
        io_div = 16'hFFFF;
        io_nstop = 1'b0;
        io_in_bits = 8'h01;
        io_in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        io_in_valid = 1'b0;
        low_cnt = 0;
        while (io_out === 1'b0 && low_cnt < 70000) begin
            low_cnt++;
            @(negedge clock);
        end
        check("maxdiv start_len", low_cnt, 32'd65536);
        check("maxdiv bit0_out", {31'd0, io_out}, 32'd1);
        check("maxdiv busy", {31'd0, io_busy}, 32'd1);
        $display("frame maxdiv byte=01 div=ffff start_clocks=%0d", low_cnt);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
